bitstream_scan_ctrl: RTL
========================

# bitstream_scan_ctrl

Sequencing controller for the team's serial pattern-detection path. Accepts a parallel word and a programmable bit pattern on a start request, serializes the word MSB-first one bit per clock, and detects the pattern Mealy-style on the live bit stream, with overlapping matches allowed. It counts matches per word and reports completion with a one-cycle done pulse. It sits between a parallel producer (CPU/register interface) and any bit-serial consumer attached to bit_out.

## Interface
- DW, 8, data word width in bits (number of serial bits per scan); DW >= PW
- PW, 3, pattern length in bits; PW >= 2
- CW, 4, match-counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  scan request, sampled only in IDLE
- din  in  DW  word to serialize, latched on accepted start
- pat  in  PW  pattern to detect, latched on accepted start; pat[PW-1] is the first (oldest) bit
- busy  out  1  high in LOAD-free SHIFT and DONE states
- bit_out  out  1  current serial bit (shift-register MSB)
- bit_valid  out  1  high exactly during the DW SHIFT cycles
- match  out  1  combinational Mealy flag: pattern completes on current bit_out
- done  out  1  one-cycle pulse at end of scan
- count  out  CW  matches in last/current scan, saturating

## Operation
- States: IDLE, SHIFT, DONE. Encoding is one-hot.
- IDLE: busy=0, bit_valid=0, match=0, done=0. count holds its last value.
  - start=1 → latch din→sreg and pat→preg, clear hist, hcnt and count, set bcnt=0, next=SHIFT.
- SHIFT: bit_out=sreg[DW-1], bit_valid=1, busy=1.
  - Each cycle: sreg shifts left by 1 with 0 fill; hist <= {hist[PW-3:0], bit_out}; hcnt increments, saturating at PW-1; bcnt increments.
  - match = (hcnt == PW-1) && ({hist[PW-2:0], bit_out} == preg). It depends on the current bit, so it is Mealy.
  - When match=1, count increments, saturating at 2^CW-1.
  - When bcnt == DW-1 → next=DONE.
- DONE: done=1, busy=1, bit_valid=0, match=0 → next=IDLE unconditionally.
- start outside IDLE, including the DONE cycle, is ignored. It is neither queued nor latched.
- History never spans words: hist and hcnt are cleared on every accepted start, so the first possible match is on serial bit index PW-1.
- Overlap: matching does not reset the history. For example, pattern 11 on 111 gives 2 matches.
- Any state other than the three legal ones → IDLE on the next clock.

## Timing
- Reset (rst=1 at a clock edge, any state including mid-SHIFT) forces state=IDLE and count=0. sreg, preg, hist, hcnt and bcnt all go to 0.
  - Outputs after reset: busy=0, bit_out=0, bit_valid=0, match=0, done=0.
  - rst has priority over start in the same cycle.
- An accepted start at edge t gives SHIFT cycles t+1 … t+DW, serial bit i (0 = MSB) in cycle t+1+i, and the DONE pulse in cycle t+DW+1. The earliest next accepted start is at the edge ending that DONE cycle's successor, i.e. it is sampled in IDLE at t+DW+2.
- count updates on the edge after match. Its final value is valid during the DONE cycle and holds through IDLE until the next accepted start.
- Throughput: one word per DW+2 cycles with back-to-back starts.

## Test plan
- Pattern pat=3'b100, din=8'b1001_0010 (bits 1,0,0,1,0,0,1,0) → match high at bit indices 2 and 5 (cycles t+3, t+6), done at t+9, count=2.
- pat=3'b111, din=8'hFF → match on bit indices 2–7, count=6. Repeat with CW=2 → count saturates at 3.
- pat=3'b010, din=8'b0101_0101 → overlapping matches at indices 2, 4, 6, count=3. pat=3'b000 with din=8'h00 → count=6.
- start held high continuously from IDLE with din=8'hA5 → exactly one scan per DW+2 cycles. din changes during SHIFT do not alter bit_out (A5 serializes as 1,0,1,0,0,1,0,1).
- Scan a word to count=2, then pulse rst in cycle t+4 → next cycle IDLE, count=0, bit_valid=0, no done pulse. A following start runs a clean scan with history cleared (first match index ≥ 2).
- Word ending in 1,0 followed by a word starting with 0 under pat=100 → no match across the boundary. count reflects only the in-word matches.

Source files
------------

// File: rtl/bitstream_scan_ctrl.sv
// Serializes a latched word MSB-first and flags a programmable pattern Mealy-style on the live bit stream.
// Latency: first bit one cycle after accepted start, done pulse DW+1 cycles after it; start is ignored unless IDLE.
module bitstream_scan_ctrl #(
  parameter int DW = 8,
  parameter int PW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic [PW-1:0] pat,
  output logic          busy,
  output logic          bit_out,
  output logic          bit_valid,
  output logic          match,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam int HW = $clog2(PW);
  localparam int BW = $clog2(DW);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_SHIFT = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [DW-1:0] r_sreg;
  logic [PW-1:0] r_preg;
  logic [PW-2:0] r_hist;
  logic [HW-1:0] r_hcnt;
  logic [BW-1:0] r_bcnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_window;
  logic          w_accept;
  logic          w_shift;
  logic          w_last;
  logic          w_match;

  // Window of the last PW bits with the live bit in the LSB, oldest bit in the MSB.
  assign w_window = {r_hist, r_sreg[DW-1]};
  assign w_last   = (r_bcnt == BW'(DW - 1));
  assign w_match  = w_shift && (r_hcnt == HW'(PW - 1)) && (w_window == r_preg);

  assign bit_out = r_sreg[DW-1];
  assign match   = w_match;
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
      S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    w_shift   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_SHIFT: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        w_shift   = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg  <= '0;
      r_preg  <= '0;
      r_hist  <= '0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sreg  <= din;
      r_preg  <= pat;
      r_hist  <= '0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_count <= '0;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[DW-2:0], 1'b0};
      r_hist <= w_window[PW-2:0];
      r_bcnt <= r_bcnt + 1'b1;
      if (r_hcnt != HW'(PW - 1)) r_hcnt <= r_hcnt + 1'b1;
      // Matching never clears history, so overlapping occurrences all count.
      if (w_match && (r_count != '1)) r_count <= r_count + 1'b1;
    end
  end

endmodule
